// File: rtl/tdm_mux8_if.sv
// rtl/tdm_mux8_if.sv - snapshot handshake and TDM lane bundle for tdm_mux8
interface tdm_mux8_if #(
  parameter int DATA_W = 1
);
  logic                  en;
  logic [8*DATA_W-1:0]   in_data;
  logic [7:0]            chan_mask;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     out_data;
  logic [2:0]            out_sel;
  logic                  out_valid;
  logic                  frame_start;
  logic                  frame_end;

  modport master (
    output en, in_data, chan_mask, in_valid,
    input  in_ready, out_data, out_sel, out_valid, frame_start, frame_end
  );

  modport slave (
    input  en, in_data, chan_mask, in_valid,
    output in_ready, out_data, out_sel, out_valid, frame_start, frame_end
  );
endinterface

// File: rtl/tdm_mux8.sv
// rtl/tdm_mux8.sv - eight-channel TDM transmitter, one channel word per slot
module tdm_mux8 #(
  parameter int DATA_W      = 1,
  parameter int SLOT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_mux8_if.slave  bus
);
  localparam int DIV_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [2:0]          slot;
  logic [DIV_W-1:0]    div;
  logic [8*DATA_W-1:0] shadow;
  logic [7:0]          mask;

  logic                frame_last;
  logic                accept;
  logic [2:0]          next_slot;
  logic [DIV_W-1:0]    next_div;

  assign frame_last   = (state == SEND) && (slot == 3'd7) && (div == DIV_LAST);
  assign bus.in_ready = bus.en && ((state == IDLE) || frame_last);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    next_slot = slot;
    next_div  = div + DIV_W'(1);
    if (div == DIV_LAST) begin
      next_slot = slot + 3'd1;
      next_div  = '0;
    end
  end

  // Outputs are computed from the next position so they line up with the registered counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      slot            <= '0;
      div             <= '0;
      shadow          <= '0;
      mask            <= '0;
      bus.out_data    <= '0;
      bus.out_sel     <= '0;
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_end   <= 1'b0;
    end else if (bus.en) begin
      if (accept) begin
        state           <= SEND;
        slot            <= '0;
        div             <= '0;
        shadow          <= bus.in_data;
        mask            <= bus.chan_mask;
        bus.out_sel     <= '0;
        bus.out_valid   <= bus.chan_mask[0];
        bus.out_data    <= bus.chan_mask[0] ? bus.in_data[DATA_W-1:0] : '0;
        bus.frame_start <= 1'b1;
        bus.frame_end   <= 1'b0;
      end else if (frame_last) begin
        state           <= IDLE;
        slot            <= '0;
        div             <= '0;
        bus.out_sel     <= '0;
        bus.out_valid   <= 1'b0;
        bus.out_data    <= '0;
        bus.frame_start <= 1'b0;
        bus.frame_end   <= 1'b0;
      end else if (state == SEND) begin
        slot            <= next_slot;
        div             <= next_div;
        bus.out_sel     <= next_slot;
        bus.out_valid   <= mask[next_slot];
        bus.out_data    <= mask[next_slot] ? shadow[int'(next_slot)*DATA_W +: DATA_W] : '0;
        bus.frame_start <= 1'b0;
        bus.frame_end   <= (next_slot == 3'd7) && (next_div == DIV_LAST);
      end
    end
  end
endmodule

// File: tb/tb_tdm_mux8.sv
// tb/tb_tdm_mux8.sv - self-checking bench for tdm_mux8 with two parameterisations
module tb_tdm_mux8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_mux8_if #(.DATA_W(1)) bus0 ();
  tdm_mux8_if #(.DATA_W(4)) bus1 ();

  tdm_mux8 #(.DATA_W(1), .SLOT_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  tdm_mux8 #(.DATA_W(4), .SLOT_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Reference: a frame is a run of 8*SC positions; position p is in slot p/SC.
  bit       m_act  [2];
  int       m_pos  [2];
  int       m_sh   [2][8];
  bit [7:0] m_mask [2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input int i, input int sc, input int w, input bit en,
                            input bit valid, input logic [31:0] data, input logic [7:0] msk);
    bit rdy;
    rdy = en && (!m_act[i] || m_pos[i] == 8*sc-1);
    if (en) begin
      if (rdy && valid) begin
        m_act[i]  = 1'b1;
        m_pos[i]  = 0;
        m_mask[i] = msk;
        for (int k = 0; k < 8; k++) m_sh[i][k] = int'((data >> (k*w)) & ((32'd1 << w) - 1));
      end else if (m_act[i]) begin
        if (m_pos[i] == 8*sc-1) m_act[i] = 1'b0;
        else m_pos[i] = m_pos[i] + 1;
      end
    end
  endtask

  task automatic model_out(input int i, input int sc, input bit en, output int sel, output int vld,
                           output int data, output int fs, output int fe, output int rdy);
    sel = 0; vld = 0; data = 0; fs = 0; fe = 0;
    rdy = int'(en && (!m_act[i] || m_pos[i] == 8*sc-1));
    if (m_act[i]) begin
      sel  = m_pos[i] / sc;
      vld  = int'(m_mask[i][sel]);
      data = (vld != 0) ? m_sh[i][sel] : 0;
      fs   = int'(m_pos[i] == 0);
      fe   = int'(m_pos[i] == 8*sc-1);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_pos[i] = 0; m_mask[i] = '0;
        for (int k = 0; k < 8; k++) m_sh[i][k] = 0;
      end
    end else begin
      model_step(0, 1, 1, bus0.en, bus0.in_valid, 32'(bus0.in_data), bus0.chan_mask);
      model_step(1, 3, 4, bus1.en, bus1.in_valid, bus1.in_data, bus1.chan_mask);
    end
  end

  always @(negedge clk) begin
    int s, v, d, fs, fe, r;
    model_out(0, 1, bus0.en, s, v, d, fs, fe, r);
    chk("m0_sel", int'(bus0.out_sel), s);
    chk("m0_valid", int'(bus0.out_valid), v);
    chk("m0_data", int'(bus0.out_data), d);
    chk("m0_fstart", int'(bus0.frame_start), fs);
    chk("m0_fend", int'(bus0.frame_end), fe);
    chk("m0_ready", int'(bus0.in_ready), r);
    model_out(1, 3, bus1.en, s, v, d, fs, fe, r);
    chk("m1_sel", int'(bus1.out_sel), s);
    chk("m1_valid", int'(bus1.out_valid), v);
    chk("m1_data", int'(bus1.out_data), d);
    chk("m1_fstart", int'(bus1.frame_start), fs);
    chk("m1_fend", int'(bus1.frame_end), fe);
    chk("m1_ready", int'(bus1.in_ready), r);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] msk;
    int c;
    bit stalled;

    bus0.en = 1'b1; bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.chan_mask = '0;
    bus1.en = 1'b1; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.chan_mask = '0;

    // Reset held: inputs toggle, outputs stay clear, in_ready follows en.
    for (int n = 0; n < 4; n++) begin
      bus0.in_valid = 1'b1; bus0.in_data = 8'($urandom); bus0.chan_mask = 8'($urandom);
      bus1.in_valid = 1'b1; bus1.in_data = $urandom;
      step();
      chk("rst_valid", int'(bus0.out_valid), 0);
      chk("rst_sel", int'(bus1.out_sel), 0);
      chk("rst_ready", int'(bus0.in_ready), 1);
    end
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single frame, SLOT_CYCLES=1.
    pat = 8'b1010_0110;
    bus0.in_data = pat; bus0.chan_mask = 8'hFF; bus0.in_valid = 1'b1;
    step();
    bus0.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("f1_sel", int'(bus0.out_sel), k);
      chk("f1_data", int'(bus0.out_data), int'(pat[k]));
      chk("f1_fstart", int'(bus0.frame_start), int'(k == 0));
      chk("f1_fend", int'(bus0.frame_end), int'(k == 7));
      chk("f1_ready", int'(bus0.in_ready), int'(k == 7));
      step();
    end
    chk("f1_idle_valid", int'(bus0.out_valid), 0);
    chk("f1_idle_ready", int'(bus0.in_ready), 1);

    // Masked frame with a three-cycle enable stall in slot 4.
    msk = 8'b0000_0101;
    bus0.in_data = 8'hFF; bus0.chan_mask = msk; bus0.in_valid = 1'b1;
    step();
    bus0.in_valid = 1'b0;
    c = 1; stalled = 1'b0;
    while (!bus0.frame_end && c < 20) begin
      chk("mk_valid", int'(bus0.out_valid), int'(msk[bus0.out_sel]));
      chk("mk_data", int'(bus0.out_data), int'(msk[bus0.out_sel]));
      if (bus0.out_sel == 3'd4 && !stalled) begin
        stalled = 1'b1;
        bus0.en = 1'b0;
        #1;
        chk("stall_ready", int'(bus0.in_ready), 0);
        repeat (3) begin
          step(); c++;
          chk("stall_sel", int'(bus0.out_sel), 4);
        end
        bus0.en = 1'b1;
      end
      step(); c++;
    end
    chk("stall_fend_cycle", c, 11);
    chk("stall_last_sel", int'(bus0.out_sel), 7);

    // SLOT_CYCLES=3, channel k carries k+1, then async reset inside slot 5.
    bus1.in_data = 32'h8765_4321; bus1.chan_mask = 8'hFF; bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("s3_sel", int'(bus1.out_sel), k / 3);
      chk("s3_data", int'(bus1.out_data), k / 3 + 1);
      step();
    end
    chk("s3_pre_rst_sel", int'(bus1.out_sel), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sel", int'(bus1.out_sel), 0);
    chk("arst_data", int'(bus1.out_data), 0);
    chk("arst_valid", int'(bus1.out_valid), 0);
    chk("arst_ready", int'(bus1.in_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", int'(bus1.in_ready), 1);
    chk("post_rst_valid", int'(bus1.out_valid), 0);

    // Random traffic against the reference.
    for (int n = 0; n < 1500; n++) begin
      bus0.en = ($urandom_range(0, 7) != 0);
      bus0.in_valid = ($urandom_range(0, 3) != 0);
      bus0.in_data = 8'($urandom);
      bus0.chan_mask = 8'($urandom);
      bus1.en = ($urandom_range(0, 7) != 0);
      bus1.in_valid = ($urandom_range(0, 2) != 0);
      bus1.in_data = $urandom;
      bus1.chan_mask = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
